clk_period_monitor: RTL and testbench
=====================================

CLK_PERIOD_MONITOR -- requirements
Module: clk_period_monitor

Interface
REQ-001 Parameter CNT_W, 8, width of the cycle counter and of the measurement outputs.
REQ-002 Parameter EXP_PERIOD, 4, expected div_clk period in clk_in cycles.
REQ-003 Parameter TOL, 0, allowed absolute deviation from EXP_PERIOD, in cycles.
REQ-004 Parameter LOCK_COUNT, 4, number of consecutive in-tolerance measurements required to declare lock.
REQ-005 Parameter TIMEOUT, 16, cycles without a rising edge before timeout; must satisfy TIMEOUT <= 2^CNT_W-1.
REQ-006 clk_in  input  1  single system clock; all logic is on its rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 div_clk  input  1  monitored divided clock; treated as asynchronous.
REQ-009 clear_err  input  1  synchronous clear of timeout_err.
REQ-010 period  output  CNT_W  last measured rise-to-rise period, in clk_in cycles.
REQ-011 high_time  output  CNT_W  last measured rise-to-fall high time, in clk_in cycles.
REQ-012 meas_valid  output  1  one-cycle pulse when period and high_time update.
REQ-013 locked  output  1  period stable within tolerance.
REQ-014 timeout_err  output  1  sticky flag: no rising edge seen within TIMEOUT cycles.

Function
REQ-015 div_clk SHALL pass through a 2-FF synchronizer and then one edge-detect register, so a rise or fall is detected 3 clk_in cycles after it occurs.
REQ-016 FSM states SHALL be SEARCH, MEASURE and LOCKED; reset state is SEARCH.
REQ-017 Counter cnt SHALL load 1 on every detected rising edge, otherwise increment by 1 per cycle, and saturate at 2^CNT_W-1.
REQ-018 On a detected falling edge, cnt SHALL be captured into a high-time holding register.
REQ-019 SEARCH: the first rising edge SHALL go to MEASURE with no meas_valid pulse, because no full period has been seen.
REQ-020 MEASURE/LOCKED: each rising edge SHALL load period with cnt and high_time with the holding register, and pulse meas_valid in that same cycle.
REQ-021 A measurement SHALL be a match when |period - EXP_PERIOD| <= TOL; a match increments match_cnt, a mismatch clears it.
REQ-022 MEASURE SHALL go to LOCKED, and locked SHALL rise, in the cycle the LOCK_COUNT-th consecutive match is registered.
REQ-023 LOCKED: a mismatch SHALL drop locked in the meas_valid cycle, return the FSM to MEASURE and clear match_cnt.
REQ-024 In any state other than SEARCH, cnt reaching TIMEOUT SHALL set timeout_err, clear locked and match_cnt, and move the FSM to SEARCH.
REQ-025 timeout_err SHALL hold until clear_err is sampled high; if set and clear occur in the same cycle, set wins.
REQ-026 period and high_time SHALL hold their values between meas_valid pulses.

Reset
REQ-027 While reset_n is low: period=0, high_time=0, meas_valid=0, locked=0, timeout_err=0; cnt, match_cnt and synchronizer flops are 0; FSM is SEARCH.
REQ-028 Reset asserted mid-measurement SHALL take effect immediately and asynchronously; after release, two rising edges are required before the next meas_valid.

Structure
REQ-029 Shared package clk_mon_pkg SHALL hold the FSM state enum and the parameter default constants.
REQ-030 The synchronizer and edge detector SHALL form one sub-module, sync_edge_detect, with rise and fall pulse outputs.

Verification
Defaults for all scenarios: CNT_W=8, EXP_PERIOD=4, TOL=0, LOCK_COUNT=4, TIMEOUT=16.
REQ-031 div_clk toggles every 2 clk_in cycles from reset release -> first meas_valid at the 2nd detected rise with period=4 and high_time=2; locked rises at the 4th meas_valid.
REQ-032 div_clk held low after lock -> timeout_err=1 and locked=0 when cnt hits 16; the next rise yields no meas_valid; the rise after that yields period=4.
REQ-033 While locked, one period of 6 (high 3) is injected -> meas_valid with period=6, locked falls in that cycle, and locked re-asserts after 4 further periods of 4.
REQ-034 clear_err pulsed in the same cycle timeout_err sets -> timeout_err=1; clear_err pulsed on a later cycle -> timeout_err=0 on the following cycle.
REQ-035 reset_n pulsed low between two rises while locked -> all outputs read 0 during reset; after release, locked needs 5 rises (1 to start plus 4 matching periods).
REQ-036 div_clk stuck high from reset -> no meas_valid and no timeout_err (still in SEARCH); cnt never exceeds 255.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock period monitor.
//   - default values for every monitor parameter
//   - FSM state encoding (also exported on the debug state port)
//   - in_tol(): absolute-deviation tolerance test used for lock tracking
package clk_mon_pkg;

  localparam int          CNT_W_DEF      = 8;
  localparam int unsigned EXP_PERIOD_DEF = 4;
  localparam int unsigned TOL_DEF        = 0;
  localparam int unsigned LOCK_COUNT_DEF = 4;
  localparam int unsigned TIMEOUT_DEF    = 16;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } mon_state_e;

  // True when |meas - expv| <= tol. Done in unsigned arithmetic by
  // subtracting the smaller operand from the larger one.
  function automatic logic in_tol(input int unsigned meas,
                                  input int unsigned expv,
                                  input int unsigned tol);
    int unsigned diff;
    diff = (meas >= expv) ? (meas - expv) : (expv - meas);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clk_in domain and flags its edges.
//   clk_in   : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   async_in : asynchronous input level
//   rise     : one-cycle pulse, synchronized level went 0 -> 1
//   fall     : one-cycle pulse, synchronized level went 1 -> 0
// Path: two synchronizer flops, then one edge-detect register holding the
// previous synchronized level. The pulse is acted on by the consumer at the
// third clk_in edge after the input changes.
module sync_edge_detect (
  input  logic clk_in,
  input  logic reset_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       edge_q,  edge_d;
  logic [2:0] fill_q,  fill_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    edge_d  = sync2_q;
    // fill_q[2] marks that edge_q holds a real sample rather than its reset
    // value; a level that is already high when reset releases is not a rise.
    fill_d  = {fill_q[1:0], 1'b1};
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
      fill_q  <= 3'b000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
      fill_q  <= fill_d;
    end
  end

  assign rise = fill_q[2] &  sync2_q & ~edge_q;
  assign fall = fill_q[2] & ~sync2_q &  edge_q;

endmodule

// File: rtl/clk_period_monitor.sv
// Measures the period and high time of a divided clock in clk_in cycles,
// declares lock after LOCK_COUNT consecutive in-tolerance periods and flags
// a sticky timeout when no rising edge arrives within TIMEOUT cycles.
//   clk_in      : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   div_clk     : monitored clock, asynchronous to clk_in
//   clear_err   : synchronous clear of timeout_err (a same-cycle set wins)
//   period      : last rise-to-rise period, held between measurements
//   high_time   : last rise-to-fall high time, held between measurements
//   meas_valid  : one-cycle pulse when period/high_time update
//   locked      : period stable within tolerance
//   timeout_err : sticky, no rising edge within TIMEOUT cycles
//   dbg_state   : current FSM state
// Handshake: none; meas_valid is a strobe with no back-pressure, and
// period/high_time are valid from the meas_valid cycle until the next one.
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int          CNT_W      = CNT_W_DEF,
  parameter int unsigned EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int unsigned TOL        = TOL_DEF,
  parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             div_clk,
  input  logic             clear_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout_err,
  output mon_state_e       dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_C    = CNT_W'(LOCK_COUNT);

  logic rise, fall;

  sync_edge_detect u_sync_edge_detect (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .async_in (div_clk),
    .rise     (rise),
    .fall     (fall)
  );

  mon_state_e       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] hold_q,   hold_d;
  logic [CNT_W-1:0] match_q,  match_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q,   high_d;
  logic             mv_q,     mv_d;
  logic             locked_q, locked_d;
  logic             terr_q,   terr_d;

  logic             timeout_hit;
  logic             is_match;
  logic [CNT_W-1:0] match_inc;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    match_d  = match_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    locked_d = locked_q;
    terr_d   = terr_q;

    // Cycle counter: restarts at 1 on a rise so that its value at the next
    // rise equals the rise-to-rise distance; saturates instead of wrapping.
    if (rise) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (fall) begin
      hold_d = cnt_q;
    end

    is_match  = in_tol(32'(cnt_q), EXP_PERIOD, TOL);
    match_inc = (match_q == CNT_MAX) ? match_q : (match_q + CNT_ONE);

    // A rise landing exactly on the timeout cycle still counts as an edge
    // and is measured (it will simply be a long, mismatching period).
    timeout_hit = (state_q != ST_SEARCH) && !rise && (cnt_q >= TIMEOUT_C);

    case (state_q)
      ST_SEARCH: begin
        // First rise only opens the measurement window.
        match_d = '0;
        if (rise) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE, ST_LOCKED: begin
        if (timeout_hit) begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          match_d  = '0;
        end else if (rise) begin
          period_d = cnt_q;
          high_d   = hold_q;
          mv_d     = 1'b1;
          if (is_match) begin
            match_d = match_inc;
            if (match_inc >= LOCK_C) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            match_d  = '0;
            state_d  = ST_MEASURE;
            locked_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        locked_d = 1'b0;
        match_d  = '0;
      end
    endcase

    // Set has priority over clear.
    if (timeout_hit) begin
      terr_d = 1'b1;
    end else if (clear_err) begin
      terr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_SEARCH;
      cnt_q    <= '0;
      hold_q   <= '0;
      match_q  <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      match_q  <= match_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      terr_q   <= terr_d;
    end
  end

  assign period      = period_q;
  assign high_time   = high_q;
  assign meas_valid  = mv_q;
  assign locked      = locked_q;
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Directed bench for clk_period_monitor with default parameters.
// Expected measurements are queued as {period, high_time} and popped on
// each meas_valid; locked is recorded at every meas_valid and compared
// against hand-computed patterns.
module tb_clk_period_monitor;
  import clk_mon_pkg::*;

  logic       clk_in    = 1'b0;
  logic       reset_n   = 1'b0;
  logic       div_clk   = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] period;
  logic [7:0] high_time;
  logic       meas_valid;
  logic       locked;
  logic       timeout_err;
  mon_state_e dbg_state;

  clk_period_monitor dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .div_clk     (div_clk),
    .clear_err   (clear_err),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .timeout_err (timeout_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int         n_chk = 0;
  int         n_bad = 0;
  int         tick_n = 0;
  int         mv_cnt = 0;
  int         last_mv_tick = 0;
  logic [15:0] exp_q[$];
  logic        lock_hist[$];
  logic [15:0] mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // One clock step: wait for the falling edge, then observe outputs.
  task automatic tick();
    @(negedge clk_in);
    tick_n++;
    if (reset_n && meas_valid) begin
      mv_cnt++;
      last_mv_tick = tick_n;
      lock_hist.push_back(locked);
      if (exp_q.size() == 0) begin
        check("exp_q_depth", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", period, mon_e[15:8]);
        check("high_time", high_time, mon_e[7:0]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) begin tick(); div_clk = 1'b1; end
    for (int i = 0; i < lo; i++) begin tick(); div_clk = 1'b0; end
  endtask

  // Asserts reset away from any clock edge and checks outputs right away.
  task automatic do_reset(input logic div_lvl);
    tick();
    #2;
    reset_n   = 1'b0;
    div_clk   = div_lvl;
    clear_err = 1'b0;
    #1;
    check("rst_period", period, 0);
    check("rst_high_time", high_time, 0);
    check("rst_meas_valid", meas_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_state", dbg_state, ST_SEARCH);
    idle(2);
    exp_q.delete();
    lock_hist.delete();
    mv_cnt = 0;
    reset_n = 1'b1;
  endtask

  task automatic check_hist(input int n, input logic [15:0] exp_bits);
    check("mv_count", mv_cnt, n);
    for (int i = 0; i < n; i++) begin
      if (i < lock_hist.size())
        check($sformatf("locked_mv%0d", i + 1), lock_hist[i], exp_bits[i]);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // S1: steady toggling every 2 cycles; lock at the 4th measurement.
    do_reset(1'b0);
    repeat (5) exp_q.push_back({8'd4, 8'd2});
    repeat (6) run_period(2, 2);
    idle(1);
    check_hist(5, 16'b1_1000);
    check("s1_exp_left", exp_q.size(), 0);
    check("s1_state", dbg_state, ST_LOCKED);

    // S2: div_clk held low after lock -> timeout at cnt == 16, with
    // clear_err coinciding with the set cycle (set wins).
    for (int i = 0; i < 40 && tick_n != last_mv_tick + 15; i++) tick();
    check("s2_to_wait", tick_n - last_mv_tick, 15);
    check("s2_terr_before", timeout_err, 0);
    check("s2_locked_before", locked, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("s2_terr_set_wins", timeout_err, 1);
    check("s2_locked_dropped", locked, 0);
    check("s2_state_search", dbg_state, ST_SEARCH);
    idle(5);
    check("s2_terr_sticky", timeout_err, 1);
    check("s2_period_hold", period, 4);
    check("s2_high_hold", high_time, 2);
    tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("s2_terr_cleared", timeout_err, 0);
    // First rise after timeout only restarts; the second measures.
    exp_q.push_back({8'd4, 8'd2});
    run_period(2, 2);
    run_period(2, 2);
    idle(2);
    check_hist(6, 16'b01_1000);
    check("s2_exp_left", exp_q.size(), 0);
    check("s2_state_measure", dbg_state, ST_MEASURE);

    // S3: one 6-cycle period (high 3) while locked, then relock.
    do_reset(1'b0);
    repeat (5) exp_q.push_back({8'd4, 8'd2});
    exp_q.push_back({8'd6, 8'd3});
    repeat (4) exp_q.push_back({8'd4, 8'd2});
    repeat (5) run_period(2, 2);
    run_period(3, 3);
    repeat (5) run_period(2, 2);
    idle(1);
    check_hist(10, 16'h0218);
    check("s3_exp_left", exp_q.size(), 0);

    // S4: reset pulse between rises while locked; relock needs 5 rises.
    do_reset(1'b0);
    repeat (4) exp_q.push_back({8'd4, 8'd2});
    repeat (5) run_period(2, 2);
    idle(1);
    check("s4_locked_pre", locked, 1);
    check("s4_period_pre", period, 4);
    do_reset(1'b0);
    repeat (5) exp_q.push_back({8'd4, 8'd2});
    repeat (6) run_period(2, 2);
    idle(1);
    check_hist(5, 16'b1_1000);
    check("s4_exp_left", exp_q.size(), 0);

    // S5: div_clk stuck high from reset -> stays in SEARCH, no error.
    do_reset(1'b1);
    idle(300);
    check("s5_mv_count", mv_cnt, 0);
    check("s5_terr", timeout_err, 0);
    check("s5_state", dbg_state, ST_SEARCH);
    check("s5_period", period, 0);
    check("s5_locked", locked, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
